sphere_stream_reader: RTL
=========================

SPHERE_STREAM_READER -- requirements
Module: sphere_stream_reader

Interface
REQ-001 The block SHALL have parameters CACHE_WIDTH (default 512, width of one stored line), REC_W (default 128, width of one record) and ADDR_W (default 32, width of the RAM read address).
REQ-002 The clock, input, 1 bit, SHALL be named clk, and all logic SHALL be on its rising edge.
REQ-003 The reset, input, 1 bit, SHALL be named reset_n, and SHALL be asynchronous and active-low.
REQ-004 start, input, 1 bit: level-sensitive go, driven by the upstream loader's done.
REQ-005 line_cnt, input, 32 bits: number of lines to stream, sampled on the start cycle.
REQ-006 mem_rd_addr, output, ADDR_W bits: read address to the upstream 512-bit line RAM.
REQ-007 mem_rd_data, input, CACHE_WIDTH bits: RAM read data, valid one cycle after mem_rd_addr is sampled.
REQ-008 rec_data, output, REC_W bits: record payload with x=[31:0], y=[63:32], z=[95:64], r=[127:96].
REQ-009 rec_valid, output, 1 bit: rec_data is valid.
REQ-010 rec_ready, input, 1 bit: the consumer accepts the record.
REQ-011 rec_last, output, 1 bit: the current record is slot 3 of the final line.
REQ-012 rec_count, output, 32 bits: number of records accepted since the last start.
REQ-013 done, output, 1 bit: streaming is complete.

Function
REQ-014 The FSM SHALL have the states IDLE, RD, CAP, EMIT and DONE.
REQ-015 IDLE with start=1 SHALL latch line_cnt into lim, clear line_idx, slot and rec_count, and go to RD, or go to DONE if line_cnt==0.
REQ-016 RD SHALL drive mem_rd_addr=line_idx and go to CAP next cycle.
REQ-017 mem_rd_addr SHALL hold line_idx in every other state.
REQ-018 CAP SHALL register mem_rd_data into line_buf, set slot=0, and go to EMIT.
REQ-019 EMIT SHALL drive rec_data=line_buf[REC_W*slot +: REC_W] and rec_valid=1.
REQ-020 A transfer SHALL occur only on a cycle with rec_valid and rec_ready both high.
REQ-021 rec_data SHALL be held stable while rec_valid=1 and rec_ready=0.
REQ-022 On a transfer with slot<3, slot SHALL increment.
REQ-023 On a transfer with slot==3, line_idx SHALL increment; if line_idx+1==lim the FSM SHALL go to DONE, otherwise to RD.
REQ-024 The line rate SHALL be 6 cycles per line with rec_ready held at 1: RD, CAP, then 4 EMIT cycles.
REQ-025 rec_count SHALL increment by 1 on each transfer and SHALL wrap modulo 2^32.
REQ-026 rec_last SHALL equal rec_valid AND (slot==3) AND (line_idx==lim-1).
REQ-027 DONE SHALL drive done=1, rec_valid=0 and rec_last=0.
REQ-028 DONE SHALL return to IDLE only when start=0, so a level start never retriggers the block.
REQ-029 start SHALL be ignored outside IDLE.
REQ-030 Changes to line_cnt after the start cycle SHALL have no effect.
REQ-031 rec_valid SHALL never be asserted in IDLE, RD, CAP or DONE.

Reset
REQ-032 With reset_n=0, and regardless of the current state (including mid-EMIT), the block SHALL immediately set state=IDLE and clear line_idx, slot, lim, rec_count and line_buf.
REQ-033 With reset_n=0, the block SHALL drive mem_rd_addr=0, rec_valid=0, rec_last=0, done=0 and rec_data=0.
REQ-034 After reset release, the first action SHALL be to await start=1 in IDLE.

Configuration
REQ-035 The block SHALL support the macro RADIUS_FILTER_EN.
REQ-036 When RADIUS_FILTER_EN is defined, an EMIT slot whose r field ==32'd0 SHALL hold rec_valid=0 for exactly one cycle and then advance as if transferred.
REQ-037 When RADIUS_FILTER_EN is defined, a filtered slot SHALL leave rec_count unchanged.
REQ-038 When RADIUS_FILTER_EN is defined and slot 3 of the final line is filtered, rec_last SHALL never assert, and the FSM SHALL still reach DONE.
REQ-039 When RADIUS_FILTER_EN is undefined, every slot SHALL be emitted, including those with r==0, and no filter logic SHALL be synthesized.

Verification
REQ-040 The bench SHALL check: line_cnt=2, rec_ready=1, RAM lines holding words 0..31 -> 8 records in order; record 0 has x=0, y=1, z=2, r=3; rec_last set only on record 7; done set 12 cycles after leaving IDLE; rec_count=8.
REQ-041 The bench SHALL check: line_cnt=0 with start=1 -> DONE on the next cycle, no rec_valid, rec_count=0.
REQ-042 The bench SHALL check: line_cnt=1 with rec_ready held 0 for 5 cycles at slot 1 -> rec_data stable and rec_valid=1 throughout, and no record lost or duplicated.
REQ-043 The bench SHALL check: start held 1 after DONE -> no restart; drop start, then raise it with line_cnt=1 -> 4 fresh records and rec_count restarts from 0.
REQ-044 The bench SHALL check: reset_n pulsed low during EMIT at slot 2 -> all outputs 0 within the same cycle; after release, IDLE is held until start.
REQ-045 The bench SHALL check, with RADIUS_FILTER_EN defined: one line with r=0 in slots 1 and 3 -> only slots 0 and 2 are emitted, rec_count=2, rec_last never asserts, done asserts.

Source files
------------

// File: rtl/sphere_stream_reader.sv
// sphere_stream_reader: reads wide lines from an upstream line RAM and
// streams each one out as four fixed-width sphere records {r, z, y, x}
// over a valid/ready handshake. Each line takes RD (address), CAP (capture
// the read data), then one EMIT cycle per record. A level start is
// consumed once; DONE waits for start to drop before returning to IDLE.
// Optional feature macro: RADIUS_FILTER_EN -- records whose r field is zero
// are dropped: they spend one cycle with rec_valid low, then the slot
// advances without a transfer and without counting.
module sphere_stream_reader #(
  parameter int CACHE_WIDTH = 512,
  parameter int REC_W       = 128,
  parameter int ADDR_W      = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [31:0]            line_cnt,
  output logic [ADDR_W-1:0]      mem_rd_addr,
  input  logic [CACHE_WIDTH-1:0] mem_rd_data,
  output logic [REC_W-1:0]       rec_data,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic                   rec_last,
  output logic [31:0]            rec_count,
  output logic                   done
);

  localparam int SLOTS  = CACHE_WIDTH / REC_W;
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

  typedef enum logic [2:0] {IDLE, RD, CAP, EMIT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [31:0]            lim_q, lim_d;
  logic [31:0]            line_idx_q, line_idx_d;
  logic [SLOT_W-1:0]      slot_q, slot_d;
  logic [31:0]            rec_count_q, rec_count_d;
  logic [CACHE_WIDTH-1:0] line_buf_q, line_buf_d;

  logic [REC_W-1:0] cur_rec;
  logic             skip;
  logic             valid;
  logic             xfer;
  logic             advance;
  logic             last_line;

  // Current record and handshake qualifiers.
  always_comb begin
    cur_rec = line_buf_q[REC_W*slot_q +: REC_W];
`ifdef RADIUS_FILTER_EN
    skip = (state_q == EMIT) && (cur_rec[REC_W-1 -: 32] == 32'd0);
`else
    skip = 1'b0;
`endif
    valid     = (state_q == EMIT) && !skip;
    xfer      = valid && rec_ready;
    advance   = xfer || skip;
    last_line = (line_idx_q + 32'd1) == lim_q;
  end

  // Next-state and datapath updates.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; an unassigned path in always_comb would infer a latch.
  always_comb begin
    state_d     = state_q;
    lim_d       = lim_q;
    line_idx_d  = line_idx_q;
    slot_d      = slot_q;
    rec_count_d = rec_count_q;
    line_buf_d  = line_buf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          lim_d       = line_cnt;
          line_idx_d  = '0;
          slot_d      = '0;
          rec_count_d = '0;
          state_d     = (line_cnt == 32'd0) ? DONE : RD;
        end
      end
      RD: state_d = CAP;
      CAP: begin
        line_buf_d = mem_rd_data;
        slot_d     = '0;
        state_d    = EMIT;
      end
      EMIT: begin
        if (xfer) rec_count_d = rec_count_q + 32'd1;
        if (advance) begin
          if (slot_q == LAST_SLOT) begin
            line_idx_d = line_idx_q + 32'd1;
            state_d    = last_line ? DONE : RD;
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
      end
      DONE: if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  // NOTE: line_buf is a flip-flop line buffer, not a RAM macro, so clearing
  // it on reset is legal and keeps rec_data at zero while reset is held.
  // Sequential state uses non-blocking assignments so every register sees
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      lim_q       <= '0;
      line_idx_q  <= '0;
      slot_q      <= '0;
      rec_count_q <= '0;
      line_buf_q  <= '0;
    end else begin
      state_q     <= state_d;
      lim_q       <= lim_d;
      line_idx_q  <= line_idx_d;
      slot_q      <= slot_d;
      rec_count_q <= rec_count_d;
      line_buf_q  <= line_buf_d;
    end
  end

  // Output decode straight from the registers.
  always_comb begin
    mem_rd_addr = ADDR_W'(line_idx_q);
    rec_data    = (state_q == EMIT) ? cur_rec : '0;
    rec_valid   = valid;
    rec_last    = valid && (slot_q == LAST_SLOT) && (line_idx_q == lim_q - 32'd1);
    rec_count   = rec_count_q;
    done        = (state_q == DONE);
  end

endmodule
